// File: rtl/nsa_pkg.sv
// Shared constants and FSM state encoding for the nibble-serial adder.
package nsa_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_e;

endpackage : nsa_pkg

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice.
module cla4_slice
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // Every carry is formed directly from generate/propagate terms, not rippled.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ c;

endmodule : cla4_slice

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one nibble per cycle through a single CLA slice, valid/ready on both sides.
// Optional signed-overflow output enabled by NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NIBBLES  = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  nsa_state_e                          state_q, state_d;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]    a_q, a_d;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]    b_q, b_d;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]    sum_q, sum_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic                                carry_q, carry_d;
  logic                                in_ready_q, in_ready_d;
  logic                                out_valid_q, out_valid_d;
  logic [NIBBLE_W-1:0]                 slice_s;
  logic                                slice_co;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic                                ovf_q, ovf_d;
`endif

  cla4_slice u_slice (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_co)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ovf_d       = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          carry_d    = cin;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q] = slice_s;
        carry_d      = slice_co;
        idx_d        = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          ovf_d = (a_q[NIBBLES-1][NIBBLE_W-1] == b_q[NIBBLES-1][NIBBLE_W-1])
               && (slice_s[NIBBLE_W-1] != a_q[NIBBLES-1][NIBBLE_W-1]);
`endif
        end
      end
      DONE: begin
        // Returning through IDLE guarantees a bubble between consecutive results.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = carry_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder at WIDTH=16.
module tb_nibble_serial_adder;

  localparam int unsigned WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Count edges after the accepting edge; out_valid must rise on exactly the 4th.
  task automatic latency_check(input string tag);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      check(tag, 64'(out_valid), 64'(e == 4));
      if (e < 4) check({tag, "_busy"}, 64'(in_ready), 64'd0);
    end
  endtask

  task automatic result_check(input string tag, input logic [WIDTH-1:0] esum,
                              input logic ecout, input logic eovf);
    check({tag, "_sum"}, 64'(sum), 64'(esum));
    check({tag, "_cout"}, 64'(cout), 64'(ecout));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, 64'(ovf), 64'(eovf));
`else
    if (eovf === 1'bx) $display("note: unexpected x in ovf expectation");
`endif
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ov_low"}, 64'(out_valid), 64'd0);
    check({tag, "_idle_rdy"}, 64'(in_ready), 64'd1);
  endtask

  // Full transaction; operands are scrambled right after accept to prove they were latched.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic vcin, input logic [WIDTH-1:0] esum, input logic ecout,
                        input logic eovf);
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    a = va; b = vb; cin = vcin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~va; b = va ^ 16'h5A5A; cin = ~vcin;
    latency_check({tag, "_lat"});
    result_check(tag, esum, ecout, eovf);
    drain(tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("v1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("vffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("vffff_cin", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op("va5a5", 16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op("vzero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    run_op("v7fff", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("v0001", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    run_op("v8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Back-pressure in DONE with competing requests, then the bubble before the next accept.
    check("stall_rdy", 64'(in_ready), 64'd1);
    a = 16'h0F0F; b = 16'h00F1; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    latency_check("stall_lat");
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      a = 16'h1111 * 16'(k + 1); b = 16'hFFFF; cin = 1'b1;
      @(posedge clk); #1;
      check("stall_ov", 64'(out_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      result_check("stall", 16'h1000, 1'b0, 1'b0);
    end
    a = 16'h8000; b = 16'h8000; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bubble_ov", 64'(out_valid), 64'd0);
    check("bubble_rdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bubble_accept", 64'(in_ready), 64'd0);
    latency_check("bubble_lat");
    result_check("bubble", 16'h0000, 1'b1, 1'b1);
    drain("bubble");

    // Reset mid-RUN: partial sum nibbles must be wiped and the result never presented.
    a = 16'h1111; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_run_ov", 64'(out_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rdy", 64'(in_ready), 64'd1);
    check("mid_rst_ov", 64'(out_valid), 64'd0);
    check("mid_rst_sum", 64'(sum), 64'd0);
    check("mid_rst_cout", 64'(cout), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("hold_rst_ov", 64'(out_valid), 64'd0);
    check("hold_rst_sum", 64'(sum), 64'd0);
    rst_n = 1'b1;
    run_op("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
    for (int e = 0; e < 6; e++) begin
      @(posedge clk); #1;
      check("post_rst_quiet", 64'(out_valid), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_nibble_serial_adder
